// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Converts PS/2 scan-code bytes into press/release events for four game lanes
//   (A/S/K/L) plus Enter. A prefix FSM handles the F0 (break) and E0 (extended)
//   prefixes. Per-key held state suppresses typematic repeats. Events are queued
//   in a small FIFO that is drained over a valid/ready handshake.
//
// Ports
//   clk_in      system clock
//   rst         asynchronous, active-high reset
//   byte_valid  one-cycle pulse, byte_data holds a received byte
//   byte_data   received scan-code byte
//   frame_err   one-cycle pulse, receiver framing/parity error
//   evt_valid   FIFO non-empty
//   evt_data    head event {press, key_id[2:0]}; 0 when the FIFO is empty
//   evt_ready   consumer accepts the head event
//   key_state   held level per key, bit index = key_id
//   overflow    sticky, an event was dropped because the FIFO was full
//   ovf_clr     clears overflow
//   busy        prefix FSM is not idle
module ps2_key_event_ctrl #(
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    input  logic       frame_err,
    output logic       evt_valid,
    output logic [3:0] evt_data,
    input  logic       evt_ready,
    output logic [4:0] key_state,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t        state, state_nx;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [4:0]    key_state_nx;
    logic          push;
    logic [3:0]    push_data;
    logic          mapped;
    logic [2:0]    key_id;

    // Scan-code to lane map. F0/E0 fall through as unmapped, which is what
    // makes a prefix byte seen in BRK behave like any other unknown code.
    always_comb begin
        mapped = 1'b1;
        key_id = 3'd0;
        case (byte_data)
            8'h1C:   key_id = 3'd0;
            8'h1B:   key_id = 3'd1;
            8'h42:   key_id = 3'd2;
            8'h4B:   key_id = 3'd3;
            8'h5A:   key_id = 3'd4;
            default: mapped = 1'b0;
        endcase
    end

    // Prefix FSM, key state and event generation.
    // Priority: frame_err > byte_valid > timeout.
    always_comb begin
        state_nx     = state;
        tcnt_nx      = tcnt;
        key_state_nx = key_state;
        push         = 1'b0;
        push_data    = 4'h0;
        if (frame_err) begin
            state_nx = IDLE;
            tcnt_nx  = '0;
        end else if (byte_valid) begin
            tcnt_nx = '0;
            case (state)
                IDLE: begin
                    if (byte_data == 8'hF0) begin
                        state_nx = BRK;
                    end else if (byte_data == 8'hE0) begin
                        state_nx = EXT;
                    end else if (mapped && !key_state[key_id]) begin
                        // Make; a repeat of an already held key is dropped.
                        key_state_nx[key_id] = 1'b1;
                        push                 = 1'b1;
                        push_data            = {1'b1, key_id};
                    end
                end
                BRK: begin
                    state_nx = IDLE;
                    if (mapped && key_state[key_id]) begin
                        key_state_nx[key_id] = 1'b0;
                        push                 = 1'b1;
                        push_data            = {1'b0, key_id};
                    end
                end
                // Extended codes never drive lanes; only track the prefix.
                EXT:     state_nx = (byte_data == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE) begin
            // Abandon a prefix whose follow-up byte never arrived.
            if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                state_nx = IDLE;
                tcnt_nx  = '0;
            end else begin
                tcnt_nx = tcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            key_state <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            tcnt      <= tcnt_nx;
            key_state <= key_state_nx;
            // Registered from the next state so busy tracks state exactly.
            busy      <= (state_nx != IDLE);
        end
    end

    // Event FIFO (show-ahead head).
    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          pop, full, do_push, drop;

    assign evt_valid = (cnt != '0);
    assign full      = (cnt == (AW+1)'(DEPTH));
    assign pop       = evt_valid && evt_ready;
    // When full, a simultaneous pop frees the slot the push needs.
    assign do_push   = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign evt_data  = evt_valid ? mem[rptr] : 4'h0;

    always_ff @(posedge clk_in) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({do_push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Set wins over clear.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl. Expected events are queued when the
// stimulus is driven; a monitor pops and compares them on each handshake.
module tb_ps2_key_event_ctrl;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;
    logic       evt_valid;
    logic [3:0] evt_data;
    logic       evt_ready;
    logic [4:0] key_state;
    logic       overflow;
    logic       ovf_clr;
    logic       busy;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q [$];

    ps2_key_event_ctrl #(.DEPTH(4), .TIMEOUT_CYC(64)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .key_state  (key_state),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor, sampled on the falling edge ahead of the pop edge.
    always @(negedge clk_in) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_evt", 32'(evt_data), 32'hFF);
            end else begin
                chk("evt_data", 32'(evt_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        byte_data  = b;
        byte_valid = 1'b1;
        step();
        byte_valid = 1'b0;
        repeat (gap) step();
    endtask

    initial begin
        rst = 1'b1; byte_valid = 1'b0; byte_data = 8'h00;
        frame_err = 1'b0; evt_ready = 1'b1; ovf_clr = 1'b0;
        repeat (2) step();
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_data",  32'(evt_data),  0);
        chk("rst_key_state", 32'(key_state), 0);
        chk("rst_overflow",  32'(overflow),  0);
        chk("rst_busy",      32'(busy),      0);
        rst = 1'b0;
        step();

        // Make then break of A at 50-cycle spacing.
        exp_q.push_back(4'h8); send(8'h1C, 0);
        chk("a_make_ks", 32'(key_state), 32'h01);
        chk("a_make_busy", 32'(busy), 0);
        repeat (49) step();
        send(8'hF0, 0);
        chk("f0_busy", 32'(busy), 1);
        repeat (49) step();
        exp_q.push_back(4'h0); send(8'h1C, 0);
        chk("a_brk_ks", 32'(key_state), 32'h00);
        chk("a_brk_busy", 32'(busy), 0);
        repeat (10) step();

        // Typematic repeats of S.
        exp_q.push_back(4'h9);
        send(8'h1B, 3); send(8'h1B, 3); send(8'h1B, 3);
        chk("s_repeat_ks", 32'(key_state), 32'h02);
        exp_q.push_back(4'h1);
        send(8'hF0, 3); send(8'h1B, 3);
        chk("s_brk_ks", 32'(key_state), 32'h00);
        chk("s_q_empty", 32'(exp_q.size()), 0);

        // Overflow with consumer stalled.
        evt_ready = 1'b0;
        exp_q.push_back(4'h8); exp_q.push_back(4'h9);
        exp_q.push_back(4'hA); exp_q.push_back(4'hB);
        send(8'h1C, 2); send(8'h1B, 0);
        repeat (2) step();
        send(8'h42, 2); send(8'h4B, 2);
        chk("pre_ovf", 32'(overflow), 0);
        send(8'h5A, 2);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_ks", 32'(key_state), 32'h1F);
        chk("ovf_head_valid", 32'(evt_valid), 1);
        chk("ovf_head_data", 32'(evt_data), 32'h8);
        evt_ready = 1'b1;
        repeat (8) step();
        chk("drain_valid", 32'(evt_valid), 0);
        chk("drain_q_empty", 32'(exp_q.size()), 0);
        chk("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        // Release all five, Enter included even though its make was dropped.
        exp_q.push_back(4'h0); send(8'hF0, 2); send(8'h1C, 2);
        exp_q.push_back(4'h1); send(8'hF0, 2); send(8'h1B, 2);
        exp_q.push_back(4'h2); send(8'hF0, 2); send(8'h42, 2);
        exp_q.push_back(4'h3); send(8'hF0, 2); send(8'h4B, 2);
        exp_q.push_back(4'h4); send(8'hF0, 2); send(8'h5A, 2);
        chk("rel_all_ks", 32'(key_state), 0);
        chk("rel_all_q", 32'(exp_q.size()), 0);

        // Prefix timeout.
        send(8'hF0, 0);
        repeat (63) step();
        chk("to_busy_hold", 32'(busy), 1);
        step();
        chk("to_busy_fall", 32'(busy), 0);
        exp_q.push_back(4'hA); send(8'h42, 3);
        chk("to_make_ks", 32'(key_state), 32'h04);
        exp_q.push_back(4'h2); send(8'hF0, 2); send(8'h42, 3);

        // Extended codes never drive lanes.
        send(8'hE0, 2); send(8'h5A, 2);
        send(8'hE0, 2); send(8'hF0, 2);
        chk("ext_brk_busy", 32'(busy), 1);
        send(8'h5A, 3);
        chk("ext_ks", 32'(key_state), 0);
        chk("ext_busy", 32'(busy), 0);
        chk("ext_q", 32'(exp_q.size()), 0);

        // frame_err aborts the break prefix.
        send(8'hF0, 1);
        frame_err = 1'b1; step(); frame_err = 1'b0;
        chk("ferr_busy", 32'(busy), 0);
        exp_q.push_back(4'hB); send(8'h4B, 3);
        chk("ferr_make_ks", 32'(key_state), 32'h08);
        // frame_err in the same cycle as a byte discards the byte.
        send(8'hF0, 1);
        byte_data = 8'h4B; byte_valid = 1'b1; frame_err = 1'b1;
        step();
        byte_valid = 1'b0; frame_err = 1'b0;
        chk("ferr_byte_busy", 32'(busy), 0);
        chk("ferr_byte_ks", 32'(key_state), 32'h08);
        exp_q.push_back(4'h3); send(8'hF0, 2); send(8'h4B, 3);
        chk("l_brk_ks", 32'(key_state), 0);
        chk("l_q", 32'(exp_q.size()), 0);

        // Asynchronous reset mid-sequence.
        evt_ready = 1'b0;
        send(8'h1C, 1); send(8'h1B, 1); send(8'h42, 1);
        send(8'hF0, 1);
        chk("pre_rst_busy", 32'(busy), 1);
        chk("pre_rst_valid", 32'(evt_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(evt_valid), 0);
        chk("async_rst_ks", 32'(key_state), 0);
        chk("async_rst_busy", 32'(busy), 0);
        step();
        rst = 1'b0;
        evt_ready = 1'b1;
        step();
        exp_q.push_back(4'h8); send(8'h1C, 4);
        chk("post_rst_ks", 32'(key_state), 32'h01);
        chk("final_q", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sits between the PS/2 byte receiver and the 4-lane game logic.
- Sequences the received scan-code bytes through a prefix state machine, handling F0 (break) and E0 (extended) prefixes.
- Tracks pressed/released state for lanes A/S/K/L and Enter, and suppresses typematic repeats.
- Queues press/release events in a small FIFO drained by a valid/ready handshake.

Parameters:
- DEPTH, 4, event FIFO entries; must be a power of 2, 2..16.
- TIMEOUT_CYC, 2000000, clk_in cycles a prefix state waits for its next byte before abandoning it (20 ms at 100 MHz).

Ports:
- clk_in  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- byte_valid  input  1  one-cycle pulse: byte_data holds a complete received byte
- byte_data  input  8  received scan-code byte
- frame_err  input  1  one-cycle pulse: receiver saw a bad start, stop or parity bit
- evt_valid  output  1  FIFO non-empty; evt_data is valid
- evt_data  output  4  {press(1)/release(0), key_id[2:0]}; key_id: 0=A, 1=S, 2=K, 3=L, 4=Enter
- evt_ready  input  1  consumer accepts the head event when evt_valid && evt_ready
- key_state  output  5  level per key, bit index = key_id; 1 = held
- overflow  output  1  sticky: an event was dropped because the FIFO was full
- ovf_clr  input  1  clears overflow
- busy  output  1  prefix FSM not in IDLE

Behaviour:
- Reset (async, rst=1): FSM=IDLE, key_state=0, FIFO empty, evt_valid=0, evt_data=0, overflow=0, busy=0, timeout counter=0.
- Key map: 1C=A, 1B=S, 42=K, 4B=L, 5A=Enter. Every other code is "unmapped".
- FSM states: IDLE, BRK, EXT, EXT_BRK. All transitions happen on byte_valid.
  - IDLE: F0 -> BRK; E0 -> EXT; mapped code -> make(key), stay in IDLE; any other byte -> ignored.
  - BRK: mapped code -> break(key) -> IDLE; unmapped code -> IDLE; F0 or E0 -> treated as unmapped -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, no action. Extended codes never drive lanes, so E0 5A is not Enter.
  - EXT_BRK: any byte -> IDLE, no action.
- make(k): if key_state[k]=0, set it and push {1,k}. If already 1 (typematic repeat), no change and no push.
- break(k): if key_state[k]=1, clear it and push {0,k}. Otherwise no push.
- Latency: byte_valid at edge N -> key_state and FSM updated at N+1. If the FIFO was empty, evt_valid=1 at N+1 (show-ahead head).
- frame_err: FSM -> IDLE, timeout counter cleared, key_state and FIFO untouched. If byte_valid and frame_err arrive in the same cycle, frame_err wins and the byte is discarded.
- Timeout: counts clk_in cycles while FSM != IDLE and is cleared on every byte_valid. On reaching TIMEOUT_CYC-1 the FSM returns to IDLE with no action. Counter width is clog2(TIMEOUT_CYC).
- FIFO:
  - Pop on evt_valid && evt_ready; evt_ready is ignored when empty.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits.
  - Push when full and no simultaneous pop: event dropped, overflow <= 1. key_state still updates.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: not possible, since the pushed entry is visible one cycle later.
- overflow: ovf_clr clears it. If ovf_clr and a dropping push occur in the same cycle, set wins.
- busy is a registered decode of FSM != IDLE.
- At most one push per cycle, by construction (one byte per byte_valid).

Test Plan:
- Reset, then bytes 1C; F0 1C at 50-cycle spacing -> events {1,0} then {0,0}; key_state 00001 -> 00000; busy=1 only between F0 and 1C.
- Bytes 1B 1B 1B (typematic) then F0 1B -> exactly two events, {1,1} and {0,1}; key_state[1] held through the repeats.
- evt_ready=0; press A, S, K, L, Enter (DEPTH=4) -> first 4 queued, Enter's event dropped, overflow=1, key_state=11111. Then evt_ready=1 -> pops in order 8,9,A,B (hex of evt_data). ovf_clr -> overflow=0.
- F0 then no byte for TIMEOUT_CYC cycles (bench uses TIMEOUT_CYC=64) -> busy falls after 64 cycles. A following 42 is a make: event {1,2}, key_state[2]=1.
- E0 5A, then E0 F0 5A -> no events, key_state=0. F0 then frame_err pulse, then 4B -> event {1,3} (not a break).
- Assert rst for 1 cycle mid-sequence after F0 with 3 events queued -> evt_valid=0, key_state=0, busy=0 immediately (async). A following 1C yields {1,0}.
